// File: rtl/rr_arbiter_timeslice_param.sv
// Round-robin arbiter for N requesters; an owner keeps the grant for up to SLICE
// cycles while requesting, and can hand it over early by dropping its request.
module rr_arbiter_timeslice_param #(
    parameter int N     = 4,
    parameter int SLICE = 4,
    localparam int IDW  = $clog2(N),
    localparam int CW   = $clog2(SLICE + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           slice_end,
    output logic           dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           slice_end_q, slice_end_d;

    logic           hold;
    logic           found;
    logic [IDW-1:0] pick;
    logic [IDW-1:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= IDW'(N - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            slice_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            slice_end_q <= slice_end_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        slice_end_d = 1'b0;
        found       = 1'b0;
        pick        = '0;
        idx         = '0;

        // While owning, ptr equals the owner, so the scan below skips the owner
        // and only falls back to it when nobody else is asking.
        hold = (state_q == OWN) && req[owner_q] && (cnt_q != CW'(SLICE));

        for (int i = 1; i < N; i++) begin
            idx = IDW'((int'(ptr_q) + i) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        if (hold) begin
            cnt_d = cnt_q + CW'(1);
        end else if (found) begin
            state_d = OWN;
            owner_d = pick;
            ptr_d   = pick;
            cnt_d   = CW'(1);
        end else if (req[ptr_q]) begin
            state_d = OWN;
            owner_d = ptr_q;
            cnt_d   = CW'(1);
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (state_d == OWN) begin
            gnt_d[owner_d] = 1'b1;
            slice_end_d    = (cnt_d == CW'(SLICE));
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = (state_q == OWN);
    assign gnt_id    = owner_q;
    assign slice_end = slice_end_q;
    assign dbg_state = (state_q == OWN);

endmodule
